// File: rtl/mem_responder.sv
// Backing-memory target for the mem_req/mem_resp port: byte-maskable line storage,
// fixed-latency read pipe and a programmable post-command busy window.
module mem_responder #(
    parameter int DATA_BITS    = 128,
    parameter int ADDR_BITS    = 28,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 4,
    parameter int READY_GAP    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_rw,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data
);
    localparam int BYTES = DATA_BITS / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {S_IDLE = 1'b0, S_WDATA = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_gap_cnt;
    logic [DEPTH_LOG2-1:0]   r_wr_addr;
    logic [DATA_BITS-1:0]    r_mem [DEPTH];
    logic                    r_pipe_vld  [READ_LATENCY];
    logic [DATA_BITS-1:0]    r_pipe_data [READ_LATENCY];

    logic                    w_req_ready;
    logic                    w_data_ready;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_wdata_acc;
    logic [DEPTH_LOG2-1:0]   w_rd_idx;
    logic                    w_unused_addr_hi;

    // Upper address bits are deliberately dropped: storage wraps modulo DEPTH.
    assign w_rd_idx         = mem_req_addr[DEPTH_LOG2-1:0];
    assign w_unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign w_rd_acc    = mem_req_valid && w_req_ready && !mem_req_rw;
    assign w_wr_acc    = mem_req_valid && w_req_ready &&  mem_req_rw;
    assign w_wdata_acc = w_data_ready && mem_req_data_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 4'd0;
            r_wr_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_rd_acc || w_wdata_acc) begin
                r_gap_cnt <= 4'(READY_GAP);
            end else if (r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
            if (w_wr_acc) begin
                r_wr_addr <= w_rd_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_wr_acc)           w_state_next = S_WDATA;
            S_WDATA: if (mem_req_data_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Gating with reset_n keeps ready low during reset while letting the very first
    // edge after release accept a command.
    always_comb begin
        w_req_ready  = reset_n && (r_state == S_IDLE) && (r_gap_cnt == 4'd0);
        w_data_ready = (r_state == S_WDATA);
    end

    assign mem_req_ready      = w_req_ready;
    assign mem_req_data_ready = w_data_ready;

    always_ff @(posedge clk) begin
        if (w_wdata_acc) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_req_data_mask[b]) begin
                    r_mem[r_wr_addr][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
                end
            end
        end
    end

    // Data of each stage only advances behind a valid entry, so the tail holds the
    // last returned line between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipe_vld[s]  <= 1'b0;
                r_pipe_data[s] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pipe_data[0] <= r_mem[w_rd_idx];
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                if (r_pipe_vld[s-1]) begin
                    r_pipe_data[s] <= r_pipe_data[s-1];
                end
            end
        end
    end

    assign mem_resp_valid = r_pipe_vld[READ_LATENCY-1];
    assign mem_resp_data  = r_pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a back-to-back instance for data/ordering
// tests and a READY_GAP=3 instance for the busy-window timing.
module tb_mem_responder;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid, req_ready, req_rw, dvalid, dready, resp_valid;
    logic [27:0]  req_addr;
    logic [127:0] dbits, resp_data;
    logic [15:0]  dmask;

    logic         g_valid, g_ready, g_rw, g_dvalid, g_dready, g_resp_valid;
    logic [27:0]  g_addr;
    logic [127:0] g_dbits, g_resp_data;
    logic [15:0]  g_dmask;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.READ_LATENCY(LAT), .READY_GAP(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(req_valid), .mem_req_ready(req_ready),
        .mem_req_addr(req_addr), .mem_req_rw(req_rw),
        .mem_req_data_valid(dvalid), .mem_req_data_ready(dready),
        .mem_req_data_bits(dbits), .mem_req_data_mask(dmask),
        .mem_resp_valid(resp_valid), .mem_resp_data(resp_data)
    );

    mem_responder #(.READ_LATENCY(LAT), .READY_GAP(3)) u_gap3 (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(g_valid), .mem_req_ready(g_ready),
        .mem_req_addr(g_addr), .mem_req_rw(g_rw),
        .mem_req_data_valid(g_dvalid), .mem_req_data_ready(g_dready),
        .mem_req_data_bits(g_dbits), .mem_req_data_mask(g_dmask),
        .mem_resp_valid(g_resp_valid), .mem_resp_data(g_resp_data)
    );

    // Monitor: every response pulse must match the oldest expectation in data and cycle.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got data=%h at cyc %0d, required no response", resp_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (resp_data !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL resp: got data=%h cyc=%0d, required data=%h cyc=%0d",
                             resp_data, cyc, e.data, e.due);
                end else begin
                    $display("resp ok data=%h cyc=%0d", resp_data, cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end else begin
            $display("check %s ok (%h)", name, got);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b after %0d cycles, required 1", req_ready, n);
        end
    endtask

    task automatic rd(input logic [27:0] a, input logic [127:0] exp, input bit push);
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = a;
        wait_ready();
        if (push) sb_q.push_back('{data: exp, due: cyc + LAT});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m, input bit early);
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = a;
        dbits     = d;
        dmask     = m;
        dvalid    = early;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wdata_ready_after_cmd", {127'd0, dready}, 128'd1);
        chk("req_ready_in_wdata", {127'd0, req_ready}, 128'd0);
        dvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dvalid = 1'b0;
        chk("wdata_ready_after_data", {127'd0, dready}, 128'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic gap3_cmd(input bit is_wr);
        int n = 0;
        @(negedge clk);
        g_valid = 1'b1;
        g_rw    = is_wr;
        g_addr  = 28'h9;
        while (g_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        g_valid = 1'b0;
        if (is_wr) begin
            g_dvalid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            g_dvalid = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            chk("gap3_ready_low", {127'd0, g_ready}, 128'd0);
            @(negedge clk);
        end
        chk("gap3_ready_high", {127'd0, g_ready}, 128'd1);
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {4{w}};
    endfunction

    localparam logic [127:0] D1   = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] EXP2 = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
    localparam logic [127:0] D3   = 128'h33333333_44444444_55555555_66666666;
    localparam logic [127:0] D4   = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [127:0] DA   = 128'hAAAA0000_AAAA1111_AAAA2222_AAAA3333;
    localparam logic [127:0] DB   = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; dvalid = 1'b0; dbits = '0; dmask = '0;
        g_valid = 1'b0; g_rw = 1'b0; g_addr = '0; g_dvalid = 1'b0; g_dbits = DB; g_dmask = '1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {127'd0, req_ready}, 128'd0);
        chk("reset_data_ready", {127'd0, dready}, 128'd0);
        chk("reset_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("reset_resp_data", resp_data, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {127'd0, req_ready}, 128'd1);

        // Basic write then read with full mask.
        wr(28'h005, D1, 16'hFFFF, 1'b0);
        rd(28'h005, D1, 1'b1);
        idle();

        // Partial mask overwrites only bytes 4..7.
        wr(28'h010, '1, 16'hFFFF, 1'b0);
        wr(28'h010, '0, 16'h00F0, 1'b0);
        rd(28'h010, EXP2, 1'b1);
        idle();

        // Back-to-back reads with READY_GAP=0.
        for (int i = 0; i < 4; i++) wr(28'(i), pat(i), 16'hFFFF, 1'b0);
        for (int i = 0; i < 4; i++) rd(28'(i), pat(i), 1'b1);
        idle();
        drain();
        chk("resp_data_hold", resp_data, pat(3));

        // Address wrap: 0x405 aliases 0x005.
        rd(28'h405, D1, 1'b1);
        idle();

        // Data valid early: must not be consumed on the command edge.
        wr(28'h020, D3, 16'hFFFF, 1'b1);
        rd(28'h020, D3, 1'b1);
        idle();

        // Read in flight keeps its snapshot across a later write.
        rd(28'h005, D1, 1'b1);
        wr(28'h005, D4, 16'hFFFF, 1'b0);
        rd(28'h005, D4, 1'b1);
        idle();
        drain();

        // Reset during WDATA with two reads in flight.
        wr(28'h007, DA, 16'hFFFF, 1'b0);
        rd(28'h000, '0, 1'b0);
        rd(28'h001, '0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 28'h007; dbits = DB; dmask = '1; dvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_data_ready", {127'd0, dready}, 128'd0);
        chk("abort_req_ready", {127'd0, req_ready}, 128'd0);
        repeat (2) @(negedge clk);
        dvalid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_first_edge_after_reset", {127'd0, req_ready}, 128'd1);
        rd(28'h007, DA, 1'b1);
        idle();
        repeat (8) @(negedge clk);
        drain();

        // Busy window of 3 cycles after a read and after a write.
        gap3_cmd(1'b0);
        gap3_cmd(1'b1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
